data_mem_resp: RTL
==================

DATA_MEM_RESP -- requirements
Module: data_mem_resp

Interface
Parameters:
REQ-001 The block SHALL have parameter DEPTH_LOG2, default 8, giving the number of address bits for 32-bit words (DEPTH = 2^DEPTH_LOG2).
REQ-002 The block SHALL have parameter BASE_ADDR, default 32'h10010000, giving the byte address of word 0.

Ports (name, direction, width, meaning):
REQ-003 CLK  in  1  single clock; all state updates occur on its rising edge.
REQ-004 ASYNC_RSTn  in  1  reset, asynchronous, active-low.
REQ-005 CLR  in  1  synchronous request to re-run the clear sequence.
REQ-006 Address  in  32  byte address from the core data port.
REQ-007 Data_IN  in  32  write data from the core.
REQ-008 WE  in  1  write strobe.
REQ-009 RE  in  1  read strobe.
REQ-010 Data_OUT  out  32  read data to the core.
REQ-011 Ready  out  1  memory initialised and accepting accesses.
REQ-012 ERR  out  1  sticky flag for an out-of-range or misaligned access.

Function
REQ-013 The block SHALL hold DEPTH words of 32 bits in a register array.
REQ-014 The block SHALL decode an access as in range when Address >= BASE_ADDR, Address < BASE_ADDR + 4*DEPTH, and Address[1:0] == 2'b00.
REQ-015 For an in-range access, the block SHALL compute the word index as (Address - BASE_ADDR)[DEPTH_LOG2+1:2], using 32-bit unsigned subtraction.
REQ-016 The FSM SHALL have two states, CLEAR and SERVE, and SHALL enter CLEAR on reset.
REQ-017 In CLEAR, the block SHALL write zero to array[clr_cnt] every cycle, where clr_cnt is a DEPTH_LOG2-bit counter starting at 0.
REQ-018 In CLEAR, the block SHALL move to SERVE in the cycle after clr_cnt == DEPTH-1 is written, so CLEAR lasts exactly DEPTH cycles.
REQ-019 Ready SHALL be 1 only in SERVE.
REQ-020 In SERVE, CLR=1 SHALL reset clr_cnt to 0 and enter CLEAR on the next edge; ERR SHALL be preserved.
REQ-021 In CLEAR, CLR=1 SHALL restart clr_cnt at 0.
REQ-022 In CLEAR, the block SHALL ignore WE and RE, hold Data_OUT at 0, and leave ERR unchanged.
REQ-023 In SERVE, when RE=1 and the access is in range, Data_OUT SHALL combinationally equal array[index] in the same cycle (zero-latency read); otherwise Data_OUT SHALL be 0.
REQ-024 In SERVE, when WE=1 and the access is in range, the block SHALL write Data_IN into array[index] at the rising edge.
REQ-025 When WE and RE are both 1 for the same index, Data_OUT SHALL show the pre-write value in that cycle and the new value from the next cycle onward.
REQ-026 In SERVE, WE=1 or RE=1 with an out-of-range or misaligned address SHALL leave the array unchanged, return Data_OUT=0, and set ERR=1 at the next edge.
REQ-027 ERR SHALL remain set until reset.
REQ-028 Address values that wrap past 32'hFFFFFFFF SHALL NOT alias into the array; REQ-014 is evaluated on the raw 32-bit value.

Reset
REQ-029 Assertion of ASYNC_RSTn=0 SHALL immediately force state=CLEAR, clr_cnt=0, Ready=0, ERR=0 and Data_OUT=0, independent of CLK.
REQ-030 Array contents SHALL NOT be reset asynchronously; the CLEAR sequence zeroes them.
REQ-031 Reset asserted mid-CLEAR or mid-SERVE SHALL abort the current operation; no write SHALL occur on the edge on which reset is low.
REQ-032 Release of reset SHALL take effect on the first rising edge at which ASYNC_RSTn=1.

Verification
REQ-033 Reset release with DEPTH_LOG2=8 -> Ready=0 for exactly 256 cycles, then Ready=1; RE at 32'h10010000 -> Data_OUT=0.
REQ-034 In SERVE, WE at 32'h10010004 with 32'hDEADBEEF, then RE at the same address next cycle -> Data_OUT=32'hDEADBEEF; ERR=0.
REQ-035 Simultaneous WE/RE at 32'h10010008, old value 0, Data_IN 32'h12345678 -> Data_OUT=0 that cycle, 32'h12345678 the next cycle with RE still 1.
REQ-036 WE to 32'h10010400 (one past end), then to 32'h10010002 (misaligned) -> no array change, Data_OUT=0, ERR=1 after the first edge and still 1 after CLR.
REQ-037 After writing 32'hA5A5A5A5 to the last word (32'h100103FC), pulse CLR -> Ready=0 for 256 cycles, then RE at 32'h100103FC -> Data_OUT=0.
REQ-038 Assert ASYNC_RSTn low mid-cycle during SERVE with WE=1 -> Ready and ERR drop at once, no write occurs, and the CLEAR sequence restarts from 0 after release.

Source files
------------

// File: rtl/data_mem_resp.sv
// Word-addressed data memory for a core data port with zero-latency reads,
// a self-clearing startup sequence and a sticky access-error flag.
module data_mem_resp #(
  parameter int          DEPTH_LOG2 = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h10010000
) (
  input  logic        CLK,
  input  logic        ASYNC_RSTn,
  input  logic        CLR,
  input  logic [31:0] Address,
  input  logic [31:0] Data_IN,
  input  logic        WE,
  input  logic        RE,
  output logic [31:0] Data_OUT,
  output logic        Ready,
  output logic        ERR
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  // 33-bit end bound so a window touching the top of the address space cannot wrap
  localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + (33'(DEPTH) << 2);

  typedef enum logic {
    CLEAR,
    SERVE
  } state_t;

  state_t                state;
  state_t                next_state;
  logic [DEPTH_LOG2-1:0] clr_cnt;
  logic [DEPTH_LOG2-1:0] next_cnt;
  logic [DEPTH_LOG2-1:0] index;
  logic [DEPTH_LOG2-1:0] mem_idx;
  logic [31:0]           mem_wdata;
  logic [31:0]           offset;
  logic [31:0]           mem [DEPTH];
  logic                  in_range;
  logic                  mem_we;
  logic                  err_set;

  assign in_range = (Address >= BASE_ADDR) &&
                    ({1'b0, Address} < END_ADDR) &&
                    (Address[1:0] == 2'b00);
  assign offset   = Address - BASE_ADDR;
  assign index    = DEPTH_LOG2'(offset >> 2);

  always_comb begin
    next_state = state;
    next_cnt   = clr_cnt;
    mem_we     = 1'b0;
    mem_idx    = index;
    mem_wdata  = Data_IN;
    err_set    = 1'b0;
    Data_OUT   = '0;
    Ready      = 1'b0;
    case (state)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_idx   = clr_cnt;
        mem_wdata = '0;
        if (CLR) begin
          next_cnt = '0;
        end else if (&clr_cnt) begin
          next_state = SERVE;
          next_cnt   = '0;
        end else begin
          next_cnt = clr_cnt + DEPTH_LOG2'(1);
        end
      end
      SERVE: begin
        Ready = 1'b1;
        // Read returns the pre-edge contents, so a same-cycle write shows up next cycle
        if (RE && in_range) begin
          Data_OUT = mem[index];
        end
        if (WE && in_range) begin
          mem_we = 1'b1;
        end
        if ((WE || RE) && !in_range) begin
          err_set = 1'b1;
        end
        if (CLR) begin
          next_state = CLEAR;
          next_cnt   = '0;
        end
      end
      default: begin
        next_state = CLEAR;
      end
    endcase
  end

  // The array shares the reset process so no write lands while reset is held
  always_ff @(posedge CLK or negedge ASYNC_RSTn) begin
    if (!ASYNC_RSTn) begin
      state   <= CLEAR;
      clr_cnt <= '0;
      ERR     <= 1'b0;
    end else begin
      state   <= next_state;
      clr_cnt <= next_cnt;
      if (err_set) begin
        ERR <= 1'b1;
      end
      if (mem_we) begin
        mem[mem_idx] <= mem_wdata;
      end
    end
  end

endmodule
